// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target register bank.
// Contents: FSM state encoding, ACK/NACK bus levels, bit-counter width.
package i2c_target_pkg;

    localparam int unsigned BIT_CNT_W = 4;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

endpackage

// File: rtl/i2c_target_regbank_if.sv
// Pin and local-port bundle of the I2C target register bank.
// Pins: scl_in, sda_in (raw levels), sda_oe (1 = pull SDA low).
// Local port: loc_addr/loc_we/loc_wdata in, loc_rdata out.
// Status: i2c_wr pulse with i2c_wr_idx, busy.
interface i2c_target_regbank_if #(
    parameter int unsigned REG_AW = 3
);
    logic              scl_in;
    logic              sda_in;
    logic              sda_oe;
    logic [REG_AW-1:0] loc_addr;
    logic              loc_we;
    logic [7:0]        loc_wdata;
    logic [7:0]        loc_rdata;
    logic              i2c_wr;
    logic [REG_AW-1:0] i2c_wr_idx;
    logic              busy;

    modport slave (
        input  scl_in, sda_in, loc_addr, loc_we, loc_wdata,
        output sda_oe, loc_rdata, i2c_wr, i2c_wr_idx, busy
    );

    modport master (
        output scl_in, sda_in, loc_addr, loc_we, loc_wdata,
        input  sda_oe, loc_rdata, i2c_wr, i2c_wr_idx, busy
    );
endinterface

// File: rtl/i2c_line_filter.sv
// Conditions one raw bus line: 2-flop synchroniser, then a FILT_LEN-sample
// majority-free filter (level accepted only after FILT_LEN equal samples).
// Ports: clk, reset_n, raw (pin level) in; filt (filtered level),
//        rise/fall (1-cycle pulses aligned with filt changing) out.
module i2c_line_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic filt,
    output logic rise,
    output logic fall
);

    localparam int unsigned HIST_W = (FILT_LEN > 1) ? FILT_LEN - 1 : 1;

    logic [1:0]          sync_q;
    logic [HIST_W-1:0]   hist_q;
    logic [FILT_LEN-1:0] window_c;
    logic                filt_nxt_c;

    // Window = current synchronised sample plus the FILT_LEN-1 before it.
    always_comb begin
        window_c   = FILT_LEN'({hist_q, sync_q[1]});
        filt_nxt_c = filt;
        if (&window_c) begin
            filt_nxt_c = 1'b1;
        end else if (~|window_c) begin
            filt_nxt_c = 1'b0;
        end
    end

    // Idle bus level is high, so everything resets to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            hist_q <= '1;
            filt   <= 1'b1;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            hist_q <= HIST_W'({hist_q, sync_q[1]});
            filt   <= filt_nxt_c;
            rise   <= filt_nxt_c & ~filt;
            fall   <= ~filt_nxt_c & filt;
        end
    end

endmodule

// File: rtl/i2c_target_regbank.sv
// I2C target serving a 2**REG_AW byte register bank with an auto-incrementing
// pointer, plus a local read/write port into the same bank.
// Ports: clk, reset_n (async, active-low); bus (slave modport) carrying
//        scl_in/sda_in/sda_oe, the local port and the i2c_wr/busy status.
module i2c_target_regbank
    import i2c_target_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned REG_AW   = 3,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    i2c_target_regbank_if.slave  bus
);

    localparam int unsigned DEPTH = 2 ** REG_AW;

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    state_t                 state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]             shreg_q, shreg_d;
    logic [REG_AW-1:0]      ptr_q, ptr_d;
    logic                   rw_q, rw_d;
    logic                   m_ack_q, m_ack_d;
    logic                   sda_oe_q, sda_oe_d;
    logic                   busy_q, busy_d;
    logic                   i2c_wr_q, i2c_wr_d;
    logic [REG_AW-1:0]      wr_idx_q, wr_idx_d;
    logic [7:0]             bank_q [DEPTH];
    logic [7:0]             loc_rdata_q;

    logic start_c, stop_c, byte_end_c, rd_load_c;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (bus.scl_in),
        .filt    (scl_f),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (bus.sda_in),
        .filt    (sda_f),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    assign start_c    = sda_fall & scl_f;
    assign stop_c     = sda_rise & scl_f;
    assign byte_end_c = scl_fall && (bit_cnt_q == BIT_CNT_W'(8));

    // Next-state and bus-side outputs.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        m_ack_d   = m_ack_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        i2c_wr_d  = 1'b0;
        wr_idx_d  = wr_idx_q;
        rd_load_c = 1'b0;

        if (start_c) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_c) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            // Receive states shift SDA in MSB first on every SCL rise.
            if (scl_rise && (state_q inside {ADDR, PTR, WDATA})) begin
                shreg_d   = {shreg_q[6:0], sda_f};
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end

            case (state_q)
                ADDR: begin
                    if (byte_end_c) begin
                        bit_cnt_d = '0;
                        if (shreg_q[7:1] == DEV_ADDR) begin
                            state_d  = ADDR_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rw_d     = shreg_q[0];
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                PTR: begin
                    if (byte_end_c) begin
                        bit_cnt_d = '0;
                        ptr_d     = shreg_q[REG_AW-1:0];
                        state_d   = PTR_ACK;
                        sda_oe_d  = 1'b1;
                    end
                end
                WDATA: begin
                    if (byte_end_c) begin
                        bit_cnt_d = '0;
                        i2c_wr_d  = 1'b1;
                        wr_idx_d  = ptr_q;
                        ptr_d     = ptr_q + REG_AW'(1);
                        state_d   = WDATA_ACK;
                        sda_oe_d  = 1'b1;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        if (rw_q) begin
                            rd_load_c = 1'b1;
                        end else begin
                            state_d = PTR;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = WDATA;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end else if (byte_end_c) begin
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                        state_d   = RDATA_ACK;
                    end else if (scl_fall) begin
                        shreg_d  = {shreg_q[6:0], 1'b0};
                        sda_oe_d = ~shreg_q[6];
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        m_ack_d = sda_f;
                    end else if (scl_fall) begin
                        if (m_ack_q == ACK) begin
                            rd_load_c = 1'b1;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                default: ;
            endcase

            // Next read byte: fetch, post-increment the pointer, drive bit 7 now.
            if (rd_load_c) begin
                state_d   = RDATA;
                bit_cnt_d = '0;
                shreg_d   = bank_q[ptr_q];
                ptr_d     = ptr_q + REG_AW'(1);
                sda_oe_d  = ~bank_q[ptr_q][7];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            m_ack_q   <= NACK;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            i2c_wr_q  <= 1'b0;
            wr_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            m_ack_q   <= m_ack_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            i2c_wr_q  <= i2c_wr_d;
            wr_idx_q  <= wr_idx_d;
        end
    end

    // Bank storage; the I2C write is issued last so it overrides a same-index local write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
            loc_rdata_q <= '0;
        end else begin
            loc_rdata_q <= bank_q[bus.loc_addr];
            if (bus.loc_we) begin
                bank_q[bus.loc_addr] <= bus.loc_wdata;
            end
            if (i2c_wr_d) begin
                bank_q[ptr_q] <= shreg_q;
            end
        end
    end

    assign bus.sda_oe     = sda_oe_q;
    assign bus.busy       = busy_q;
    assign bus.i2c_wr     = i2c_wr_q;
    assign bus.i2c_wr_idx = wr_idx_q;
    assign bus.loc_rdata  = loc_rdata_q;

endmodule
